// File: rtl/snn_pkg.sv
// Shared types and constants for the SNN weight store slice.
// Store geometry, FSM states, requester ids and weight nibble limits.
package snn_pkg;

    localparam int DEPTH = 16;
    localparam int AW    = 4;
    localparam int DW    = 8;

    typedef enum logic {
        ST_INIT,
        ST_RUN
    } state_e;

    typedef enum logic [1:0] {
        RQ_NONE,
        RQ_HOST,
        RQ_ENG
    } rq_e;

    // Range of one signed 4-bit weight packed in a store nibble.
    localparam logic signed [3:0] W_MAX = 4'sd7;
    localparam logic signed [3:0] W_MIN = -4'sd8;

endpackage

// File: rtl/weight_regfile.sv
// Single-port DEPTH x DW weight array with registered read data.
// Ports: clk, rst_n, en/we/addr/wdata access, rdata (registered).
module weight_regfile #(
    parameter int DEPTH = snn_pkg::DEPTH,
    parameter int AW    = snn_pkg::AW,
    parameter int DW    = snn_pkg::DW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [DEPTH];
    logic          in_range;

    // Out-of-range words read as zero and swallow writes.
    assign in_range = ({1'b0, addr} < (AW+1)'(DEPTH));

    always_ff @(posedge clk) begin
        if (en && we && in_range) begin
            mem[addr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata <= '0;
        end else if (en && !we) begin
            rdata <= in_range ? mem[addr] : '0;
        end
    end

endmodule

// File: rtl/weight_store_arbiter.sv
// Weight store shared by the host loader and the SNN layer engine.
// Ports: host_* and eng_* access channels, lock_active, ready.
module weight_store_arbiter #(
    parameter int DEPTH      = snn_pkg::DEPTH,
    parameter int AW         = snn_pkg::AW,
    parameter int DW         = snn_pkg::DW,
    parameter int STARVE_MAX = 3,
    parameter int LOCK_MAX   = 15
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          host_req,
    input  logic          host_we,
    input  logic [AW-1:0] host_addr,
    input  logic [DW-1:0] host_wdata,
    output logic          host_gnt,
    output logic          host_rvalid,
    output logic [DW-1:0] host_rdata,
    input  logic          eng_req,
    input  logic          eng_we,
    input  logic [AW-1:0] eng_addr,
    input  logic [DW-1:0] eng_wdata,
    input  logic          eng_lock,
    output logic          eng_gnt,
    output logic          eng_rvalid,
    output logic [DW-1:0] eng_rdata,
    output logic          lock_active,
    output logic          ready
);
    import snn_pkg::*;

    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam int LW = $clog2(LOCK_MAX + 1);

    state_e        state_q, state_d;
    logic [AW-1:0] ptr_q;
    logic [SW-1:0] starve_q;
    logic [LW-1:0] lock_cnt;
    logic          rearm_block;
    rq_e           gnt_id;

    logic          rf_en;
    logic          rf_we;
    logic [AW-1:0] rf_addr;
    logic [DW-1:0] rf_wdata;
    logic [DW-1:0] rf_rdata;
    logic [DW-1:0] host_hold;
    logic [DW-1:0] eng_hold;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_INIT: if (ptr_q == AW'(DEPTH - 1)) state_d = ST_RUN;
            ST_RUN:  state_d = ST_RUN;
            default: state_d = ST_INIT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_INIT;
            ptr_q   <= '0;
            ready   <= 1'b0;
        end else begin
            state_q <= state_d;
            ready   <= (state_d == ST_RUN);
            if (state_q == ST_INIT) ptr_q <= ptr_q + 1'b1;
        end
    end

    // A held lock parks the port for the engine even when it is idle.
    always_comb begin
        gnt_id = RQ_NONE;
        if (state_q == ST_RUN) begin
            if (lock_active) begin
                if (eng_req) gnt_id = RQ_ENG;
            end else if (eng_req && starve_q == SW'(STARVE_MAX)) begin
                gnt_id = RQ_ENG;
            end else if (host_req) begin
                gnt_id = RQ_HOST;
            end else if (eng_req) begin
                gnt_id = RQ_ENG;
            end
        end
    end

    assign host_gnt = (gnt_id == RQ_HOST);
    assign eng_gnt  = (gnt_id == RQ_ENG);

    always_comb begin
        rf_en    = 1'b0;
        rf_we    = 1'b0;
        rf_addr  = '0;
        rf_wdata = '0;
        if (state_q == ST_INIT) begin
            rf_en   = 1'b1;
            rf_we   = 1'b1;
            rf_addr = ptr_q;
        end else if (host_gnt) begin
            rf_en    = 1'b1;
            rf_we    = host_we;
            rf_addr  = host_addr;
            rf_wdata = host_wdata;
        end else if (eng_gnt) begin
            rf_en    = 1'b1;
            rf_we    = eng_we;
            rf_addr  = eng_addr;
            rf_wdata = eng_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_q <= '0;
        end else if (eng_gnt || !eng_req) begin
            starve_q <= '0;
        end else if (host_gnt && starve_q != SW'(STARVE_MAX)) begin
            starve_q <= starve_q + 1'b1;
        end
    end

    // lock_cnt holds the number of cycles the lock has been held so far.
    // After a forced release eng_lock must drop once before re-arming.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_active <= 1'b0;
            lock_cnt    <= '0;
            rearm_block <= 1'b0;
        end else begin
            if (!eng_lock) rearm_block <= 1'b0;
            if (lock_active) begin
                if (!eng_lock) begin
                    lock_active <= 1'b0;
                    lock_cnt    <= '0;
                end else if (lock_cnt == LW'(LOCK_MAX)) begin
                    lock_active <= 1'b0;
                    lock_cnt    <= '0;
                    rearm_block <= 1'b1;
                end else begin
                    lock_cnt <= lock_cnt + 1'b1;
                end
            end else if (eng_gnt && eng_lock && !rearm_block) begin
                lock_active <= 1'b1;
                lock_cnt    <= LW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            host_rvalid <= 1'b0;
            eng_rvalid  <= 1'b0;
            host_hold   <= '0;
            eng_hold    <= '0;
        end else begin
            host_rvalid <= host_gnt && !host_we;
            eng_rvalid  <= eng_gnt && !eng_we;
            host_hold   <= host_rdata;
            eng_hold    <= eng_rdata;
        end
    end

    // The array has one read register; each side keeps its last word.
    assign host_rdata = host_rvalid ? rf_rdata : host_hold;
    assign eng_rdata  = eng_rvalid ? rf_rdata : eng_hold;

    weight_regfile #(
        .DEPTH(DEPTH),
        .AW   (AW),
        .DW   (DW)
    ) u_regfile (
        .clk  (clk),
        .rst_n(rst_n),
        .en   (rf_en),
        .we   (rf_we),
        .addr (rf_addr),
        .wdata(rf_wdata),
        .rdata(rf_rdata)
    );

endmodule

// File: tb/tb_weight_store_arbiter.sv
// Directed bench for weight_store_arbiter.
// Drives host/engine channels and checks grants, data, lock and clear.
module tb_weight_store_arbiter;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       host_req = 1'b0;
    logic       host_we = 1'b0;
    logic [3:0] host_addr = '0;
    logic [7:0] host_wdata = '0;
    logic       host_gnt;
    logic       host_rvalid;
    logic [7:0] host_rdata;
    logic       eng_req = 1'b0;
    logic       eng_we = 1'b0;
    logic [3:0] eng_addr = '0;
    logic [7:0] eng_wdata = '0;
    logic       eng_lock = 1'b0;
    logic       eng_gnt;
    logic       eng_rvalid;
    logic [7:0] eng_rdata;
    logic       lock_active;
    logic       ready;

    int n_chk = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    weight_store_arbiter dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .host_req   (host_req),
        .host_we    (host_we),
        .host_addr  (host_addr),
        .host_wdata (host_wdata),
        .host_gnt   (host_gnt),
        .host_rvalid(host_rvalid),
        .host_rdata (host_rdata),
        .eng_req    (eng_req),
        .eng_we     (eng_we),
        .eng_addr   (eng_addr),
        .eng_wdata  (eng_wdata),
        .eng_lock   (eng_lock),
        .eng_gnt    (eng_gnt),
        .eng_rvalid (eng_rvalid),
        .eng_rdata  (eng_rdata),
        .lock_active(lock_active),
        .ready      (ready)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Host access; ok reports whether a grant came within the budget.
    // Returns #1 after the edge following the grant.
    task automatic host_op(input logic we, input logic [3:0] a,
                           input logic [7:0] d, output logic ok);
        ok = 1'b0;
        host_req = 1'b1;
        host_we = we;
        host_addr = a;
        host_wdata = d;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge clk);
            ok = host_gnt;
            tick();
        end
        host_req = 1'b0;
    endtask

    task automatic wait_ready_after_release(input string tag);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        for (int i = 0; i < 16; i++) begin
            if (i > 0) @(negedge clk);
            n_chk++;
            if (ready !== 1'b0 || host_gnt !== 1'b0)
                $display("FAIL %s_init c%0d ready=%b gnt=%b want 0 0",
                         tag, i, ready, host_gnt);
            else n_pass++;
        end
        @(negedge clk);
        n_chk++;
        if (ready !== 1'b1)
            $display("FAIL %s_ready got %b want 1", tag, ready);
        else n_pass++;
    endtask

    task automatic test_reset();
        logic ok;
        #2;
        n_chk++;
        if ({host_gnt, host_rvalid, host_rdata, eng_gnt, eng_rvalid,
             eng_rdata, lock_active, ready} !== 21'h0)
            $display("FAIL reset_outs got %h want 0",
                     {host_gnt, host_rvalid, host_rdata, eng_gnt,
                      eng_rvalid, eng_rdata, lock_active, ready});
        else n_pass++;
        host_req = 1'b1;
        host_we = 1'b0;
        host_addr = 4'd0;
        wait_ready_after_release("rst");
        n_chk++;
        if (host_gnt !== 1'b1)
            $display("FAIL rst_first_gnt got %b want 1", host_gnt);
        else n_pass++;
        tick();
        host_req = 1'b0;
        for (int a = 1; a < 16; a++) begin
            host_op(1'b0, 4'(a), 8'h00, ok);
            n_chk++;
            if (!ok || host_rvalid !== 1'b1 || host_rdata !== 8'h00)
                $display("FAIL clear_rd a%0d ok=%b rv=%b d=%h want 1 1 00",
                         a, ok, host_rvalid, host_rdata);
            else n_pass++;
        end
    endtask

    task automatic test_host_eng_rw();
        logic ok;
        host_op(1'b1, 4'd3, 8'hA5, ok);
        n_chk++;
        if (!ok || host_rvalid !== 1'b0)
            $display("FAIL hw_a5 ok=%b rv=%b want 1 0", ok, host_rvalid);
        else n_pass++;
        eng_req = 1'b1;
        eng_we = 1'b0;
        eng_addr = 4'd3;
        @(negedge clk);
        n_chk++;
        if (eng_gnt !== 1'b1)
            $display("FAIL er_gnt got %b want 1", eng_gnt);
        else n_pass++;
        tick();
        eng_req = 1'b0;
        n_chk++;
        if (eng_rvalid !== 1'b1 || eng_rdata !== 8'hA5 || host_rvalid !== 1'b0)
            $display("FAIL er_data rv=%b d=%h hrv=%b want 1 a5 0",
                     eng_rvalid, eng_rdata, host_rvalid);
        else n_pass++;
        tick();
        n_chk++;
        if (eng_rvalid !== 1'b0 || eng_rdata !== 8'hA5)
            $display("FAIL er_hold rv=%b d=%h want 0 a5",
                     eng_rvalid, eng_rdata);
        else n_pass++;
    endtask

    task automatic test_starve();
        logic [7:0] pat = 8'b0111_0111;
        host_req = 1'b1;
        host_we = 1'b0;
        host_addr = 4'd1;
        eng_req = 1'b1;
        eng_we = 1'b0;
        eng_addr = 4'd2;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            n_chk++;
            if (host_gnt !== pat[i] || eng_gnt !== !pat[i])
                $display("FAIL starve c%0d h=%b e=%b want %b %b",
                         i, host_gnt, eng_gnt, pat[i], !pat[i]);
            else n_pass++;
            tick();
        end
        host_req = 1'b0;
        eng_req = 1'b0;
        tick();
    endtask

    task automatic test_lock();
        logic [3:0] ea [4] = '{4'd0, 4'd7, 4'd0, 4'd7};
        logic [7:0] ed [4] = '{8'h00, 8'h00, 8'h12, 8'h34};
        for (int i = 0; i < 4; i++) begin
            eng_req = 1'b1;
            eng_lock = 1'b1;
            eng_we = (i >= 2);
            eng_addr = ea[i];
            eng_wdata = ed[i];
            @(negedge clk);
            n_chk++;
            if (eng_gnt !== 1'b1 || host_gnt !== 1'b0)
                $display("FAIL lock_op%0d e=%b h=%b want 1 0",
                         i, eng_gnt, host_gnt);
            else n_pass++;
            tick();
            if (i < 2) begin
                n_chk++;
                if (lock_active !== 1'b1 || eng_rvalid !== 1'b1 ||
                    eng_rdata !== 8'h00)
                    $display("FAIL lock_rd%0d la=%b rv=%b d=%h want 1 1 00",
                             i, lock_active, eng_rvalid, eng_rdata);
                else n_pass++;
            end
            if (i == 0) begin
                host_req = 1'b1;
                host_we = 1'b0;
                host_addr = 4'd7;
            end
        end
        eng_req = 1'b0;
        eng_lock = 1'b0;
        @(negedge clk);
        n_chk++;
        if (host_gnt !== 1'b0 || lock_active !== 1'b1)
            $display("FAIL lock_fall h=%b la=%b want 0 1",
                     host_gnt, lock_active);
        else n_pass++;
        tick();
        @(negedge clk);
        n_chk++;
        if (host_gnt !== 1'b1 || lock_active !== 1'b0)
            $display("FAIL lock_free h=%b la=%b want 1 0",
                     host_gnt, lock_active);
        else n_pass++;
        tick();
        host_req = 1'b0;
        n_chk++;
        if (host_rvalid !== 1'b1 || host_rdata !== 8'h34)
            $display("FAIL lock_hrd rv=%b d=%h want 1 34",
                     host_rvalid, host_rdata);
        else n_pass++;
    endtask

    task automatic test_lock_timeout();
        eng_req = 1'b1;
        eng_lock = 1'b1;
        eng_we = 1'b0;
        eng_addr = 4'd5;
        @(negedge clk);
        n_chk++;
        if (eng_gnt !== 1'b1)
            $display("FAIL lto_gnt got %b want 1", eng_gnt);
        else n_pass++;
        tick();
        eng_req = 1'b0;
        host_req = 1'b1;
        host_we = 1'b0;
        host_addr = 4'd0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            n_chk++;
            if (lock_active !== 1'b1 || host_gnt !== 1'b0)
                $display("FAIL lto_hold c%0d la=%b h=%b want 1 0",
                         i, lock_active, host_gnt);
            else n_pass++;
            tick();
        end
        @(negedge clk);
        n_chk++;
        if (lock_active !== 1'b0 || host_gnt !== 1'b1)
            $display("FAIL lto_rel la=%b h=%b want 0 1",
                     lock_active, host_gnt);
        else n_pass++;
        tick();
        host_req = 1'b0;
        n_chk++;
        if (host_rvalid !== 1'b1 || host_rdata !== 8'h12)
            $display("FAIL lto_hrd rv=%b d=%h want 1 12",
                     host_rvalid, host_rdata);
        else n_pass++;
        eng_req = 1'b1;
        @(negedge clk);
        n_chk++;
        if (eng_gnt !== 1'b1)
            $display("FAIL lto_regnt got %b want 1", eng_gnt);
        else n_pass++;
        tick();
        eng_req = 1'b0;
        n_chk++;
        if (lock_active !== 1'b0)
            $display("FAIL lto_norearm la=%b want 0", lock_active);
        else n_pass++;
        eng_lock = 1'b0;
        tick();
    endtask

    task automatic test_mid_reset();
        logic ok;
        logic [3:0] ra [2] = '{4'd3, 4'd7};
        eng_req = 1'b1;
        eng_lock = 1'b1;
        eng_we = 1'b0;
        eng_addr = 4'd3;
        @(negedge clk);
        n_chk++;
        if (eng_gnt !== 1'b1)
            $display("FAIL mr_gnt got %b want 1", eng_gnt);
        else n_pass++;
        #2;
        rst_n = 1'b0;
        #1;
        n_chk++;
        if (lock_active !== 1'b0 || ready !== 1'b0 || eng_gnt !== 1'b0)
            $display("FAIL mr_async la=%b rdy=%b g=%b want 0 0 0",
                     lock_active, ready, eng_gnt);
        else n_pass++;
        tick();
        n_chk++;
        if (eng_rvalid !== 1'b0)
            $display("FAIL mr_rvalid got %b want 0", eng_rvalid);
        else n_pass++;
        eng_req = 1'b0;
        eng_lock = 1'b0;
        wait_ready_after_release("mr");
        tick();
        for (int i = 0; i < 2; i++) begin
            host_op(1'b0, ra[i], 8'h00, ok);
            n_chk++;
            if (!ok || host_rvalid !== 1'b1 || host_rdata !== 8'h00)
                $display("FAIL mr_clear a%0d ok=%b rv=%b d=%h want 1 1 00",
                         ra[i], ok, host_rvalid, host_rdata);
            else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_host_eng_rw();
        test_starve();
        test_lock();
        test_lock_timeout();
        test_mid_reset();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout passed=%0d checks=%0d", n_pass, n_chk);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/weight_store_arbiter.md
Name: weight_store_arbiter

Overview:
- Owns the 16x8 weight store, one byte per layer half: high nibble and low nibble are two signed 4-bit weights.
- Shares one single-port store between two requesters:
  - the host loader, driven from the pins;
  - the SNN layer engine, which does load-compute-write-back per layer.
- Clears the store after reset, arbitrates every cycle with host priority plus an engine anti-starvation guard, and supports an engine lock so a layer's read/write-back sequence is atomic.

Parameters:
- DEPTH, 16, number of weight words.
- AW, 4, address width (log2 DEPTH).
- DW, 8, word width (two packed 4-bit weights).
- STARVE_MAX, 3, consecutive engine losses before the engine is forced to win.
- LOCK_MAX, 15, maximum cycles the engine may hold the lock before forced release.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset.
- host_req  in  1  host access request, held until host_gnt.
- host_we  in  1  host write (1) / read (0).
- host_addr  in  AW  host word address.
- host_wdata  in  DW  host write data.
- host_gnt  out  1  host access performed this cycle.
- host_rvalid  out  1  host read data valid (1 cycle after grant).
- host_rdata  out  DW  host read data.
- eng_req  in  1  engine access request, held until eng_gnt.
- eng_we  in  1  engine write / read.
- eng_addr  in  AW  engine word address.
- eng_wdata  in  DW  engine write data.
- eng_lock  in  1  engine requests exclusive ownership.
- eng_gnt  out  1  engine access performed this cycle.
- eng_rvalid  out  1  engine read data valid.
- eng_rdata  out  DW  engine read data.
- lock_active  out  1  engine lock currently held.
- ready  out  1  init clear complete, store usable.

Behaviour:
- Reset is asynchronous, active-low, on rst_n; clock is clk.
- All outputs reset to 0; state=INIT, clear pointer=0, starve counter=0, lock counter=0.
- INIT state:
  - writes 8'h00 to address ptr each cycle, ptr 0..DEPTH-1;
  - lasts DEPTH cycles, then RUN, with ready=1 from the next cycle;
  - host_gnt and eng_gnt are held 0 and requests are ignored (requesters stay pending).
- RUN state:
  - at most one access per cycle; gnt is combinational in the same cycle as the winning req and the access happens at that clock edge;
  - write: mem[addr] <= wdata;
  - read: rdata is registered and rvalid pulses the next cycle;
  - rdata holds its last value otherwise.
- Arbitration priority, in order:
  1. lock_active and eng_req → engine wins; host waits.
  2. lock_active and no eng_req → nobody is granted.
  3. starve counter == STARVE_MAX and eng_req → engine wins.
  4. host_req → host wins.
  5. eng_req → engine wins.
- Starve counter:
  - increments (saturating) when eng_req is pending and the host is granted;
  - clears on any eng_gnt or when eng_req=0.
- Lock:
  - lock_active sets on an eng_gnt cycle with eng_lock=1;
  - clears when eng_lock falls, or when the lock counter reaches LOCK_MAX (forced release);
  - after a forced release, the lock cannot re-arm until eng_lock has been seen low for at least one cycle;
  - the lock counter counts cycles while locked and resets on release.
- Simultaneous host and engine writes to the same address: only the granted writer's data lands; the loser remains pending and is granted later, so last-granted wins.
- There is no read/write hazard: single port, accesses are serialised.
- Reset asserted mid-operation:
  - immediate return to INIT; pending rvalid is dropped; the lock is released;
  - the clear restarts from address 0.
- Address ≥ DEPTH is impossible with AW=4; for other parameterisations, reads return 0 and writes are dropped, with gnt still given.

Decomposition:
- Shared package snn_pkg:
  - AW, DW, DEPTH;
  - state enum {ST_INIT, ST_RUN};
  - requester id enum {RQ_NONE, RQ_HOST, RQ_ENG};
  - weight nibble helper constants W_MAX=4'sd7 and W_MIN=-4'sd8, for the engine.
- One sub-module: weight_regfile (DEPTH x DW single-port array with registered read).
- Arbitration, lock and starve logic stay in weight_store_arbiter.

Test Plan:
- Reset release → ready=0 for 16 cycles, then 1; reading addresses 0..15 returns 8'h00 each, and host_req raised during INIT gets no grant until ready.
- Host writes 8'hA5 to addr 3, then the engine reads addr 3 → eng_gnt in that cycle, eng_rvalid the next cycle with eng_rdata=8'hA5.
- Host and engine both request continuously → the host is granted 3 consecutive cycles, then the engine is granted once, and the pattern repeats.
- Engine sets eng_lock and reads 0, reads 7, writes 0=8'h12, writes 7=8'h34 while host_req is held high → the host gets no grant until eng_lock falls; the host's subsequent read of 7 returns 8'h34.
- eng_lock held high with no further eng_req → lock_active drops after 15 cycles and the pending host_req is granted on the next cycle.
- rst_n pulsed low during a locked engine read → eng_rvalid never fires, lock_active=0, ready=0, and the full clear repeats.
